uart_challenge_deframer: RTL and testbench

UART_CHALLENGE_DEFRAMER -- requirements
Module: uart_challenge_deframer

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_pulse_sync.sv | 29 ++
 rtl/uart_challenge_deframer.sv | 176 +++++++++++++++++
 tb/tb_uart_challenge_deframer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART challenge deframer: frame field widths,
// default start marker, FSM state encoding and a LEN legality helper.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int CHAL_W = 128;
    localparam int LEN_W  = 5;

    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_LEN,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_HOLD
    } state_t;

    // A LEN byte is usable when it is non-zero and fits the payload buffer.
    function automatic logic len_legal(input logic [BYTE_W-1:0] len, input int max_bytes);
        return (len != '0) && (int'(len) <= max_bytes);
    endfunction

endpackage

// File: rtl/uart_pulse_sync.sv
// Brings the baud-domain rx_done strobe into clk and emits a single-cycle
// pulse on each synchronized rising edge.
module uart_pulse_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/uart_challenge_deframer.sv
// Parses SYNC, LEN, payload, CHK frames from a UART byte stream into a
// 128-bit challenge with valid/ready handoff, error pulses and drop count.
module uart_challenge_deframer
    import uart_pkg::*;
#(
    parameter int                MAX_BYTES      = 16,
    parameter int                TIMEOUT_CYCLES = 50000,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_done,
    output logic [CHAL_W-1:0] chal_data,
    output logic              chal_valid,
    input  logic              chal_ready,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout,
    output logic [7:0]        drop_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              rst_meta;
    logic              rst_n_int;
    logic              byte_ev;
    state_t            state;
    state_t            state_next;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              frame_active;
    logic [CHAL_W-1:0] shreg;
    logic [LEN_W-1:0]  rem;
    logic [BYTE_W-1:0] chk;
    logic              start_frame;
    logic              shift_byte;
    logic              load_chal;
    logic              release_chal;
    logic              drop_byte;
    logic              err_chk_next;
    logic              err_len_next;
    logic              err_tmo_next;

    // Reset asserts immediately but releases only on a clk edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    uart_pulse_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n_int),
        .d     (rx_done),
        .pulse (byte_ev)
    );

    assign tmo_hit      = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign frame_active = (state_next == ST_GET_LEN) || (state_next == ST_GET_DATA) ||
                          (state_next == ST_GET_CHK);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Next-state and per-cycle control strobes; a byte event beats a timeout.
    always_comb begin
        state_next   = state;
        start_frame  = 1'b0;
        shift_byte   = 1'b0;
        load_chal    = 1'b0;
        release_chal = 1'b0;
        drop_byte    = 1'b0;
        err_chk_next = 1'b0;
        err_len_next = 1'b0;
        err_tmo_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (byte_ev && rx_data == SYNC_BYTE) state_next = ST_GET_LEN;
            end
            ST_GET_LEN: begin
                if (byte_ev) begin
                    if (len_legal(rx_data, MAX_BYTES)) begin
                        start_frame = 1'b1;
                        state_next  = ST_GET_DATA;
                    end else begin
                        err_len_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    err_tmo_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (byte_ev) begin
                    shift_byte = 1'b1;
                    if (rem == LEN_W'(1)) state_next = ST_GET_CHK;
                end else if (tmo_hit) begin
                    err_tmo_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_GET_CHK: begin
                if (byte_ev) begin
                    if (rx_data == chk) begin
                        load_chal  = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        err_chk_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    err_tmo_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                drop_byte = byte_ev;
                if (chal_valid && chal_ready) begin
                    release_chal = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Payload shift register, remaining count and running checksum; these
    // are always initialised by the LEN byte before use, so need no reset.
    always_ff @(posedge clk) begin
        if (start_frame) begin
            shreg <= '0;
            rem   <= rx_data[LEN_W-1:0];
            chk   <= rx_data;
        end else if (shift_byte) begin
            shreg <= {shreg[CHAL_W-BYTE_W-1:0], rx_data};
            rem   <= rem - LEN_W'(1);
            chk   <= chk ^ rx_data;
        end
    end

    // Output handoff, error pulses, drop counter and inter-byte timer.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            chal_data   <= '0;
            chal_valid  <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            drop_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            if (load_chal) begin
                chal_data  <= shreg;
                chal_valid <= 1'b1;
            end else if (release_chal) begin
                chal_valid <= 1'b0;
            end
            err_chk     <= err_chk_next;
            err_len     <= err_len_next;
            err_timeout <= err_tmo_next;
            if (drop_byte && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (byte_ev || !frame_active) tmo_cnt <= '0;
            else                          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_challenge_deframer.sv
// Randomized bench for uart_challenge_deframer with a frame-level reference
// model that parses the byte stream from a queue and is compared every cycle.
module tb_uart_challenge_deframer;

    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_done = 1'b0;
    logic         chal_ready = 1'b0;
    logic [127:0] chal_data;
    logic         chal_valid;
    logic         err_chk;
    logic         err_len;
    logic         err_timeout;
    logic [7:0]   drop_cnt;

    always #5 clk = ~clk;

    uart_challenge_deframer #(
        .MAX_BYTES      (16),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .chal_data   (chal_data),
        .chal_valid  (chal_valid),
        .chal_ready  (chal_ready),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } ev_t;

    ev_t          evq[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           n_echk = 0;
    int           n_elen = 0;
    int           n_etmo = 0;
    bit           rand_ready = 0;

    logic         m_valid = 0;
    logic [127:0] m_data = '0;
    logic         m_echk = 0;
    logic         m_elen = 0;
    logic         m_etmo = 0;
    int           m_drop = 0;
    bit           in_frame = 0;
    logic [7:0]   fb[$];
    int           idle = 0;

    // Reference model: a byte is seen 3 clocks after rx_done rises; frames
    // are collected in a queue and judged when complete.
    always @(posedge clk) begin : model
        logic       have;
        logic [7:0] b;
        logic [7:0] x;
        int         len;
        cyc++;
        m_echk = 0;
        m_elen = 0;
        m_etmo = 0;
        have   = 0;
        b      = 8'h00;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            have = 1;
            b    = evq[0].b;
            evq.delete(0);
        end
        if (!reset) begin
            m_valid  = 0;
            m_data   = '0;
            m_drop   = 0;
            in_frame = 0;
            idle     = 0;
            fb.delete();
            evq.delete();
        end else if (m_valid) begin
            if (have && m_drop < 255) m_drop++;
            if (chal_ready) m_valid = 0;
        end else if (have) begin
            idle = 0;
            if (!in_frame) begin
                if (b == 8'hA5) begin
                    in_frame = 1;
                    fb.delete();
                end
            end else begin
                fb.push_back(b);
                len = int'(fb[0]);
                if (fb.size() == 1) begin
                    if (len == 0 || len > 16) begin
                        m_elen   = 1;
                        in_frame = 0;
                    end
                end else if (fb.size() == len + 2) begin
                    x = 8'h00;
                    for (int i = 0; i < fb.size() - 1; i++) x ^= fb[i];
                    if (x == b) begin
                        m_data = '0;
                        for (int i = 1; i <= len; i++) m_data[8*(len-i) +: 8] = fb[i];
                        m_valid = 1;
                    end else begin
                        m_echk = 1;
                    end
                    in_frame = 0;
                end
            end
        end else if (in_frame) begin
            idle++;
            if (idle == TMO) begin
                m_etmo   = 1;
                in_frame = 0;
                idle     = 0;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ready) chal_ready = ($urandom_range(1, 0) == 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lat);
        int hi;
        int lo;
        hi = lat ? 2 : int'($urandom_range(3, 2));
        lo = int'($urandom_range(5, 2));
        rx_data = b;
        rx_done = 1'b1;
        evq.push_back('{cyc + 3, b});
        for (int i = 0; i < hi; i++) begin
            tick();
            if (lat && i == 1) check("latency_before", 128'(chal_valid), 128'(0));
        end
        rx_done = 1'b0;
        for (int i = 0; i < lo; i++) begin
            tick();
            if (lat && i == 0) check("latency_rise", 128'(chal_valid), 128'(1));
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] pl[16], input bit bad, input bit lat);
        logic [7:0] c;
        c = 8'(len);
        send_byte(8'hA5, 0);
        send_byte(8'(len), 0);
        for (int i = 0; i < len; i++) begin
            send_byte(pl[i], 0);
            c ^= pl[i];
        end
        if (bad) c ^= 8'(1 << $urandom_range(7, 0));
        send_byte(c, lat);
    endtask

    task automatic release_hold();
        chal_ready = 1'b1;
        tick();
        chal_ready = 1'b0;
    endtask

    logic [7:0] pl[16];
    int         base;
    int         r;
    int         len;

    initial begin
        fork
            forever begin
                @(posedge clk);
                #2;
                check("chal_valid", 128'(chal_valid), 128'(m_valid));
                check("chal_data", chal_data, m_data);
                check("err_chk", 128'(err_chk), 128'(m_echk));
                check("err_len", 128'(err_len), 128'(m_elen));
                check("err_timeout", 128'(err_timeout), 128'(m_etmo));
                check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
                n_echk += int'(err_chk);
                n_elen += int'(err_len);
                n_etmo += int'(err_timeout);
            end
            begin
                #5000000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (4) tick();
        check("reset_valid", 128'(chal_valid), 128'(0));
        check("reset_data", chal_data, 128'(0));
        check("reset_errs", 128'({err_chk, err_len, err_timeout}), 128'(0));
        check("reset_drop", 128'(drop_cnt), 128'(0));
        reset = 1'b1;
        repeat (4) tick();

        // Full-length frame preceded by garbage; checks latency and ordering.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        for (int i = 0; i < 16; i++) pl[i] = 8'(i);
        send_frame(16, pl, 0, 1);
        check("len16_data", chal_data, 128'h000102030405060708090A0B0C0D0E0F);
        check("len16_model", m_data, 128'h000102030405060708090A0B0C0D0E0F);
        release_hold();
        check("len16_release", 128'(chal_valid), 128'(0));

        // Short frame is right-aligned: A5,02,DE,AD,71.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'h71, 0);
        check("dead_valid", 128'(chal_valid), 128'(1));
        check("dead_data", chal_data, 128'h0000DEAD);
        release_hold();

        // Bad checksum.
        base = n_echk;
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'h00, 0);
        repeat (3) tick();
        check("badchk_pulses", 128'(n_echk - base), 128'(1));
        check("badchk_valid", 128'(chal_valid), 128'(0));
        check("badchk_data", chal_data, 128'h0000DEAD);

        // Illegal LEN values 0 and 17.
        base = n_elen;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h11, 0);
        repeat (3) tick();
        check("badlen_pulses", 128'(n_elen - base), 128'(2));

        // Timeout mid-frame, then a clean frame is still accepted.
        base = n_etmo;
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        repeat (TMO + 5) tick();
        check("timeout_pulses", 128'(n_etmo - base), 128'(1));
        pl[0] = 8'h12; pl[1] = 8'h34; pl[2] = 8'h56; pl[3] = 8'h78;
        send_frame(4, pl, 0, 0);
        check("after_tmo_valid", 128'(chal_valid), 128'(1));
        check("after_tmo_data", chal_data, 128'h12345678);
        release_hold();

        // Stalled output: 300 bytes dropped, counter saturates.
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        send_frame(3, pl, 0, 0);
        for (int i = 0; i < 300; i++) send_byte(8'($urandom), 0);
        check("drop_sat", 128'(drop_cnt), 128'(255));
        check("drop_data", chal_data, 128'h010203);
        check("drop_valid", 128'(chal_valid), 128'(1));
        release_hold();

        // Reset in the middle of a frame clears everything with no error.
        base = n_echk + n_elen + n_etmo;
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        reset = 1'b0;
        tick();
        check("midrst_data", chal_data, 128'(0));
        check("midrst_drop", 128'(drop_cnt), 128'(0));
        check("midrst_valid", 128'(chal_valid), 128'(0));
        reset = 1'b1;
        repeat (TMO + 5) tick();
        check("midrst_no_err", 128'(n_echk + n_elen + n_etmo - base), 128'(0));

        // Reset during HOLD discards the pending challenge.
        send_frame(3, pl, 0, 0);
        check("hold_valid", 128'(chal_valid), 128'(1));
        reset = 1'b0;
        tick();
        check("holdrst_valid", 128'(chal_valid), 128'(0));
        check("holdrst_data", chal_data, 128'(0));
        reset = 1'b1;
        repeat (4) tick();

        // Randomized traffic with random backpressure.
        rand_ready = 1;
        for (int f = 0; f < 150; f++) begin
            r = int'($urandom_range(9, 0));
            if (r == 0) begin
                send_byte(8'($urandom), 0);
            end else if (r == 1) begin
                send_byte(8'hA5, 0);
                send_byte(($urandom_range(1, 0) == 1) ? 8'h00 : 8'($urandom_range(255, 17)), 0);
            end else if (r == 2) begin
                len = int'($urandom_range(16, 1));
                send_byte(8'hA5, 0);
                send_byte(8'(len), 0);
                for (int i = 0; i < int'($urandom_range(len, 0)); i++) send_byte(8'($urandom), 0);
                repeat (TMO + 3) tick();
            end else begin
                len = int'($urandom_range(16, 1));
                for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
                send_frame(len, pl, ($urandom_range(5, 0) == 0), 0);
            end
        end
        rand_ready = 0;
        chal_ready = 1'b1;
        repeat (TMO + 10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
